// File: rtl/hangman_pkg.sv
// Shared definitions for the hangman game controller.
//   - Letter code range of the randomizer (6'hA = 'A' .. 6'h23 = 'Z')
//   - Default display code for an unrevealed position
//   - Controller state encoding
//   - Mapping from a letter code to its bit in the 26-bit guessed vector
package hangman_pkg;

  localparam logic [5:0] LETTER_A       = 6'hA;
  localparam logic [5:0] LETTER_Z       = 6'h23;
  localparam logic [5:0] BLANK_CODE_DEF = 6'h24;
  localparam int         NUM_LETTERS    = 26;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PLAY  = 3'd1,
    CHECK = 3'd2,
    WIN   = 3'd3,
    LOSE  = 3'd4
  } hm_state_e;

  // Only meaningful for in-range codes; callers must check the range first.
  function automatic logic [4:0] code_to_idx(input logic [5:0] code);
    return 5'(code - LETTER_A);
  endfunction

endpackage

// File: rtl/hangman_letter_match.sv
// Combinational letter comparator.
//   word_i     : the four latched letter codes, [0] = first position
//   guess_i    : guessed letter code
//   match_o    : bit i set when position i+1 holds the guessed letter
//   in_range_o : guess lies within LETTER_A..LETTER_Z
module hangman_letter_match
  import hangman_pkg::*;
(
  input  logic [3:0][5:0] word_i,
  input  logic [5:0]      guess_i,
  output logic [3:0]      match_o,
  output logic            in_range_o
);

  always_comb begin
    match_o = '0;
    for (int i = 0; i < 4; i++) begin
      match_o[i] = (word_i[i] == guess_i);
    end
  end

  assign in_range_o = (guess_i >= LETTER_A) && (guess_i <= LETTER_Z);

endmodule

// File: rtl/hangman_game_ctrl.sv
// Hangman game controller.
// Latches the randomizer's four-letter word on start, accepts one guess at a
// time through a valid/ready handshake, reveals matching positions, counts
// down lives and declares win or lose.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   start                    begin a new game (IDLE/WIN/LOSE only)
//   word_l1..word_l4         letter codes from the randomizer
//   guess, guess_valid       guessed letter and its valid flag
//   guess_ready              high only in PLAY
//   disp1..disp4             letter if revealed (all letters in WIN/LOSE), else BLANK_CODE
//   revealed                 bit i = position i+1 revealed
//   lives                    remaining lives
//   hit, miss, repeat_g, invalid  one-cycle result pulses after a CHECK
//   win, lose                levels held until the next start or rst
//   playing                  high in PLAY or CHECK
module hangman_game_ctrl
  import hangman_pkg::*;
#(
  parameter int         MAX_LIVES  = 6,
  parameter logic [5:0] BLANK_CODE = BLANK_CODE_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [5:0] word_l1,
  input  logic [5:0] word_l2,
  input  logic [5:0] word_l3,
  input  logic [5:0] word_l4,
  input  logic [5:0] guess,
  input  logic       guess_valid,
  output logic       guess_ready,
  output logic [5:0] disp1,
  output logic [5:0] disp2,
  output logic [5:0] disp3,
  output logic [5:0] disp4,
  output logic [3:0] revealed,
  output logic [2:0] lives,
  output logic       hit,
  output logic       miss,
  output logic       repeat_g,
  output logic       invalid,
  output logic       win,
  output logic       lose,
  output logic       playing
);

  hm_state_e              state_q, state_d;
  logic [3:0][5:0]        word_q, word_d;
  logic [3:0]             revealed_q, revealed_d;
  logic [2:0]             lives_q, lives_d;
  logic [NUM_LETTERS-1:0] guessed_q, guessed_d;
  logic [5:0]             guess_q, guess_d;
  logic                   hit_q, hit_d;
  logic                   miss_q, miss_d;
  logic                   repeat_q, repeat_d;
  logic                   invalid_q, invalid_d;
  logic                   win_q, win_d;
  logic                   lose_q, lose_d;

  logic [3:0]             match;
  logic                   in_range;
  logic [4:0]             idx;
  logic [3:0][5:0]        disp_w;

  hangman_letter_match u_match (
    .word_i     (word_q),
    .guess_i    (guess_q),
    .match_o    (match),
    .in_range_o (in_range)
  );

  assign idx = code_to_idx(guess_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      word_q     <= '0;
      revealed_q <= '0;
      lives_q    <= '0;
      guessed_q  <= '0;
      guess_q    <= '0;
      hit_q      <= 1'b0;
      miss_q     <= 1'b0;
      repeat_q   <= 1'b0;
      invalid_q  <= 1'b0;
      win_q      <= 1'b0;
      lose_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_q     <= word_d;
      revealed_q <= revealed_d;
      lives_q    <= lives_d;
      guessed_q  <= guessed_d;
      guess_q    <= guess_d;
      hit_q      <= hit_d;
      miss_q     <= miss_d;
      repeat_q   <= repeat_d;
      invalid_q  <= invalid_d;
      win_q      <= win_d;
      lose_q     <= lose_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    word_d     = word_q;
    revealed_d = revealed_q;
    lives_d    = lives_q;
    guessed_d  = guessed_q;
    guess_d    = guess_q;
    hit_d      = 1'b0;
    miss_d     = 1'b0;
    repeat_d   = 1'b0;
    invalid_d  = 1'b0;
    win_d      = win_q;
    lose_d     = lose_q;

    case (state_q)
      IDLE, WIN, LOSE: begin
        if (start) begin
          word_d     = {word_l4, word_l3, word_l2, word_l1};
          revealed_d = '0;
          lives_d    = 3'(MAX_LIVES);
          guessed_d  = '0;
          win_d      = 1'b0;
          lose_d     = 1'b0;
          state_d    = PLAY;
        end
      end

      PLAY: begin
        if (guess_valid) begin
          guess_d = guess;
          state_d = CHECK;
        end
      end

      CHECK: begin
        // Priority: invalid > repeat > hit > miss. The guessed vector is only
        // indexed once the code is known to be in range.
        if (!in_range) begin
          invalid_d = 1'b1;
        end else if (guessed_q[idx]) begin
          repeat_d = 1'b1;
        end else if (|match) begin
          hit_d          = 1'b1;
          revealed_d     = revealed_q | match;
          guessed_d[idx] = 1'b1;
        end else begin
          miss_d         = 1'b1;
          guessed_d[idx] = 1'b1;
          if (lives_q != 3'd0) begin
            lives_d = lives_q - 3'd1;
          end
        end

        // Decided on the post-guess values so the final hit/miss lands
        // together with win/lose.
        if (revealed_d == 4'b1111) begin
          state_d = WIN;
          win_d   = 1'b1;
        end else if (lives_d == 3'd0) begin
          state_d = LOSE;
          lose_d  = 1'b1;
        end else begin
          state_d = PLAY;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Game over shows the whole word without touching the revealed vector.
  always_comb begin
    disp_w = '0;
    for (int i = 0; i < 4; i++) begin
      if ((state_q == WIN) || (state_q == LOSE) || revealed_q[i]) begin
        disp_w[i] = word_q[i];
      end else begin
        disp_w[i] = BLANK_CODE;
      end
    end
  end

  assign disp1       = disp_w[0];
  assign disp2       = disp_w[1];
  assign disp3       = disp_w[2];
  assign disp4       = disp_w[3];
  assign guess_ready = (state_q == PLAY);
  assign playing     = (state_q == PLAY) || (state_q == CHECK);
  assign revealed    = revealed_q;
  assign lives       = lives_q;
  assign hit         = hit_q;
  assign miss        = miss_q;
  assign repeat_g    = repeat_q;
  assign invalid     = invalid_q;
  assign win         = win_q;
  assign lose        = lose_q;

endmodule
